// File: rtl/priority_encoder_serializer.sv
// ---------------------------------------------------------------------------
// priority_encoder_serializer
//
// Captures a request vector and serialises the index of every set bit, highest
// bit first, over a valid/ready handshake. This is the inverse of a 2-to-4
// enable decoder: each emitted index can drive a decoder's select lines.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   en     in   1      enable; low pauses loading and emission
//   load   in   1      capture req when idle and enabled
//   req    in   WIDTH  request vector, bit WIDTH-1 has the highest priority
//   ready  in   1      consumer accepts y this cycle
//   y      out  IDX_W  index of the highest pending bit
//   valid  out  1      y is meaningful
//   busy   out  1      pending vector non-empty (emitting)
//   none   out  1      one-cycle pulse: load seen with req == 0
//   done   out  1      one-cycle pulse: last pending index accepted
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module priority_encoder_serializer #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] req,
  input  logic             ready,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic             busy,
  output logic             none,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] y_q,       y_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             none_q,    none_d;
  logic             done_q,    done_d;

  logic             xfer;
  logic [WIDTH-1:0] pending_clr;

  // Index of the highest set bit; scanning upward lets the last hit win.
  // Returns 0 for an all-zero vector, which callers never rely on.
  function automatic logic [IDX_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // A transfer is the consumer seeing valid and asserting ready. It is honoured
  // even if en drops in that same cycle: the consumer has already taken y, so
  // withholding the transfer would duplicate the index.
  assign xfer        = valid_q & ready;
  assign pending_clr = pending_q & ~(WIDTH'(1) << y_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    y_d       = y_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    none_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (en && load) begin
          if (req != '0) begin
            pending_d = req;
            y_d       = msb_index(req);
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_EMIT;
          end else begin
            none_d = 1'b1;
          end
        end
      end

      ST_EMIT: begin
        busy_d = 1'b1;
        if (xfer) begin
          pending_d = pending_clr;
          if (pending_clr == '0) begin
            // Last index accepted; y keeps its final value while idle.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Next index presented on the following cycle, no bubble.
            y_d     = msb_index(pending_clr);
            valid_d = en;
          end
        end else begin
          // Holding: y and pending stay put, valid follows en one cycle later.
          valid_d = en;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      none_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      none_q    <= none_d;
      done_q    <= done_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign none  = none_q;
  assign done  = done_q;

endmodule

// File: tb/tb_priority_encoder_serializer.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder_serializer
//
// Directed and randomised stimulus for priority_encoder_serializer. The
// reference model is a queue of expected indices built from the request
// vector, highest bit first; each accepted handshake pops one entry.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_priority_encoder_serializer;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] req;
  logic             ready;
  logic [IDX_W-1:0] y;
  logic             valid;
  logic             busy;
  logic             none;
  logic             done;

  int checks;
  int errors;

  priority_encoder_serializer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .req   (req),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .busy  (busy),
    .none  (none),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load r, then run the handshake with ready/en drawn at the given
  // percentages (rdy_pct < 0 means ready toggles 1,0,1,0...). Called and
  // returning on a falling edge.
  task automatic run_req(input string tag, input logic [WIDTH-1:0] r,
                         input int rdy_pct, input int en_pct);
    int          q[$];
    bit          prev_en;
    bit          exp_valid;
    int          cyc;
    int          last_idx;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r[i]) q.push_back(i);
    end
    en    = 1'b1;
    load  = 1'b1;
    req   = r;
    ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    req  = WIDTH'($urandom);
    if (q.size() == 0) begin
      check({tag, ".none_pulse"}, 32'(none),  32'd1);
      check({tag, ".none_valid"}, 32'(valid), 32'd0);
      check({tag, ".none_busy"},  32'(busy),  32'd0);
      @(negedge clk);
      check({tag, ".none_clear"}, 32'(none),  32'd0);
      check({tag, ".none_valid2"}, 32'(valid), 32'd0);
      return;
    end
    prev_en  = 1'b1;
    cyc      = 0;
    last_idx = 0;
    while (q.size() > 0) begin
      exp_valid = prev_en;
      check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
      check({tag, ".busy"},  32'(busy),  32'd1);
      check({tag, ".y"},     32'(y),     32'(q[0]));
      check({tag, ".done"},  32'(done),  32'd0);
      check({tag, ".none"},  32'(none),  32'd0);
      if (cyc >= 48) begin
        ready = 1'b1;
        en    = 1'b1;
      end else begin
        ready = (rdy_pct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < rdy_pct);
        en    = $urandom_range(99) < en_pct;
      end
      // Loads and new requests during emission must have no effect.
      load = 1'($urandom_range(1));
      req  = WIDTH'($urandom);
      if (exp_valid && ready) begin
        last_idx = q[0];
        void'(q.pop_front());
      end
      prev_en = en;
      cyc++;
      @(negedge clk);
    end
    load  = 1'b0;
    ready = 1'b0;
    check({tag, ".end_valid"}, 32'(valid), 32'd0);
    check({tag, ".end_busy"},  32'(busy),  32'd0);
    check({tag, ".end_done"},  32'(done),  32'd1);
    check({tag, ".end_none"},  32'(none),  32'd0);
    check({tag, ".end_yhold"}, 32'(y),     32'(last_idx));
    @(negedge clk);
    check({tag, ".done_clear"}, 32'(done),  32'd0);
    check({tag, ".idle_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // 1: reset held with an active load request
    rst_n = 1'b0;
    en    = 1'b1;
    load  = 1'b1;
    req   = 4'hF;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.busy",  32'(busy),  32'd0);
    check("rst.y",     32'(y),     32'd0);
    check("rst.none",  32'(none),  32'd0);
    check("rst.done",  32'(done),  32'd0);
    load  = 1'b0;
    ready = 1'b0;
    req   = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.idle_valid", 32'(valid), 32'd0);
    check("rst.idle_busy",  32'(busy),  32'd0);

    // 2: two bits, ready always high
    run_req("t2", 4'b1010, 100, 100);

    // 3: all ones, ready toggling
    run_req("t3", 4'hF, -1, 100);

    // 4: single bit, en dropped for two cycles
    en    = 1'b1;
    load  = 1'b1;
    req   = 4'b0100;
    ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check("t4.valid0", 32'(valid), 32'd1);
    check("t4.y0",     32'(y),     32'd2);
    en = 1'b0;
    @(negedge clk);
    check("t4.pause1_valid", 32'(valid), 32'd0);
    check("t4.pause1_y",     32'(y),     32'd2);
    check("t4.pause1_busy",  32'(busy),  32'd1);
    ready = 1'b1;  // ignored while valid is low
    @(negedge clk);
    check("t4.pause2_valid", 32'(valid), 32'd0);
    check("t4.pause2_busy",  32'(busy),  32'd1);
    en    = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    check("t4.resume_valid", 32'(valid), 32'd1);
    check("t4.resume_y",     32'(y),     32'd2);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t4.done",  32'(done),  32'd1);
    check("t4.valid", 32'(valid), 32'd0);
    check("t4.busy",  32'(busy),  32'd0);
    @(negedge clk);
    check("t4.done_clear", 32'(done), 32'd0);

    // 5: empty load, then a load in EMIT that must be ignored
    load = 1'b1;
    req  = '0;
    @(negedge clk);
    load = 1'b0;
    check("t5.none",  32'(none),  32'd1);
    check("t5.valid", 32'(valid), 32'd0);
    check("t5.done",  32'(done),  32'd0);
    @(negedge clk);
    check("t5.none_clear", 32'(none),  32'd0);
    check("t5.valid2",     32'(valid), 32'd0);
    load = 1'b1;
    req  = 4'b1000;
    @(negedge clk);
    check("t5.emit_valid", 32'(valid), 32'd1);
    check("t5.emit_y",     32'(y),     32'd3);
    req   = 4'b0001;
    ready = 1'b0;
    @(negedge clk);
    check("t5.hold_y",     32'(y),     32'd3);
    check("t5.hold_valid", 32'(valid), 32'd1);
    req   = 4'b0111;
    ready = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    ready = 1'b0;
    check("t5.done",  32'(done),  32'd1);
    check("t5.busy",  32'(busy),  32'd0);
    check("t5.valid", 32'(valid), 32'd0);
    check("t5.none2", 32'(none),  32'd0);
    @(negedge clk);
    check("t5.done_clear", 32'(done), 32'd0);

    // 6: asynchronous reset after one transfer of an all-ones request
    load  = 1'b1;
    req   = 4'hF;
    ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check("t6.y3", 32'(y), 32'd3);
    ready = 1'b1;
    @(negedge clk);
    check("t6.y2", 32'(y), 32'd2);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 32'(valid), 32'd0);
    check("t6.rst_busy",  32'(busy),  32'd0);
    check("t6.rst_y",     32'(y),     32'd0);
    check("t6.rst_done",  32'(done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6.after_done",  32'(done),  32'd0);
      check("t6.after_valid", 32'(valid), 32'd0);
      check("t6.after_busy",  32'(busy),  32'd0);
    end

    // Randomised requests with random ready and en activity.
    for (int n = 0; n < 24; n++) begin
      run_req("rnd", WIDTH'($urandom), 30 + int'($urandom_range(70)),
              40 + int'($urandom_range(60)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
